motor_ramp_ctrl: RTL and testbench
==================================

// Module: motor_ramp_ctrl
// PURPOSE
//  Sequencing controller in front of the dc_motor PWM block. Drives its psw (speed code) and dir inputs.
//  Accepts speed/direction commands over a valid/ready handshake.
//  Ramps psw one code at a time for soft start and soft stop.
//  Direction reversal runs as: ramp to 0, then dead time, then flip dir, then ramp up.
//  Latches faults from dc_motor fault_out and forces the motor off until software clears the fault.
// PARAMETERS
//  SPEED_W      3    width of psw / speed code (max code = 2**SPEED_W-1)
//  STEP_CYCLES  100  clk cycles per one-code psw step (>=2)
//  DEAD_CYCLES  50   clk cycles held at psw=0 before a direction flip (>=1)
// PORTS
//  clk           in   1        system clock; all logic rising-edge
//  rst_n         in   1        asynchronous active-low reset
//  cmd_valid     in   1        command present
//  cmd_ready     out  1        command accepted on cmd_valid&&cmd_ready
//  cmd_speed     in   SPEED_W  target speed code
//  cmd_dir       in   1        target direction
//  fault_in      in   1        fault from dc_motor fault_out, same clock domain
//  fault_clr     in   1        one-cycle request to leave FAULT
//  psw           out  SPEED_W  registered speed code to dc_motor
//  dir           out  1        registered direction to dc_motor
//  busy          out  1        state != IDLE
//  at_speed      out  1        state == IDLE (psw==tgt_speed, dir==tgt_dir)
//  fault_latched out  1        state == FAULT
// BEHAVIOUR
//  Reset (async, immediate):
//   - psw=0, dir=0, tgt_speed=0, tgt_dir=0, step_cnt=0, dead_cnt=0, state=IDLE.
//   - Hence busy=0, at_speed=1, fault_latched=0, cmd_ready=1.
//   - Reset mid-ramp drops psw straight to 0; no ramp-down.
//  States: IDLE, RAMP, DEAD, FAULT.
//  Command handshake:
//   - cmd_ready = (state==IDLE || state==RAMP), combinational from state only.
//   - On accept: tgt_speed<=cmd_speed, tgt_dir<=cmd_dir.
//   - IDLE->RAMP if the new target differs from (psw,dir); otherwise stay in IDLE.
//   - An accept while in RAMP retargets without restarting step_cnt.
//  Effective target: eff = (tgt_dir!=dir) ? 0 : tgt_speed.
//  RAMP:
//   - step_cnt counts 0..STEP_CYCLES-1.
//   - At STEP_CYCLES-1: psw<=psw+1 if psw<eff, psw-1 if psw>eff; step_cnt<=0.
//   - step_cnt<=0 on entry from IDLE or DEAD.
//   - psw==eff && dir==tgt_dir -> IDLE (same edge as the final step).
//   - psw==0 && eff==0 && dir!=tgt_dir -> DEAD, dead_cnt<=0.
//   - psw never changes by more than 1 per step, never wraps, never exceeds 2**SPEED_W-1.
//  DEAD:
//   - psw held 0; dead_cnt counts to DEAD_CYCLES-1.
//   - Then dir<=tgt_dir and go to RAMP (or IDLE if tgt_speed==0).
//  Latency:
//   - From rest, same dir, cmd speed s: psw reaches k at accept+k*STEP_CYCLES.
//   - Reversal from psw=p to speed s: dir flips at accept+p*STEP_CYCLES+DEAD_CYCLES.
//   - psw then reaches s a further s*STEP_CYCLES later.
//  Fault:
//   - fault_in=1 in any state -> next edge: psw<=0, tgt_speed<=0, step_cnt<=0, state<=FAULT.
//   - dir and tgt_dir are retained.
//   - Fault has priority over a same-cycle command accept; that command is consumed and discarded.
//   - FAULT->IDLE only on fault_clr=1 && fault_in=0; fault_clr while fault_in=1 is ignored.
//   - No auto-restart: a new command is required after clearing.
//  Retargeting:
//   - A command with the current dir issued during a reversal ramp-down reverses the ramp toward tgt_speed.
//   - No DEAD phase in that case.
// STRUCTURE
//  motor_ctrl_pkg:
//   - state_e enum {IDLE,RAMP,DEAD,FAULT}.
//   - localparam SPEED_W_DEF=3.
//   - function psw_max(w).
//  Sub-module motor_step_timer:
//   - Parameterised down-counter; clear/enable in, tick out.
//   - Instanced twice: step timer (STEP_CYCLES) and dead timer (DEAD_CYCLES).
//  Top level holds the FSM, target registers and psw/dir registers.
// TESTING (clk 10 ns, STEP_CYCLES=100, DEAD_CYCLES=50)
//  1. Soft start: reset, cmd(5,dir0) at cycle T.
//     -> psw=1 at T+100, psw=5 at T+500, busy 1->0 and at_speed=1 at T+500.
//  2. Reversal: at psw=5 dir0, cmd(3,dir1) at T.
//     -> psw 0 at T+500, cmd_ready=0 during DEAD, dir=1 at T+550, psw=3 at T+850.
//  3. Fault: 10-cycle fault_in pulse at psw=2.
//     -> psw=0 next edge, fault_latched=1, cmd_ready=0.
//     -> fault_clr during fault_in ignored; fault_clr after -> IDLE, psw stays 0.
//  4. Retarget: cmd(7,dir0), then cmd(1,dir0) at psw=3.
//     -> psw goes 3->2->1, no step above 3, step_cnt phase kept.
//  5. Reset mid-op: rst_n low at psw=4.
//     -> psw=0, dir=0 before the next clk edge.
//     -> cmd_ready=1 after release.
//  6. Sweep: commands 0..7 in turn, each awaited to at_speed.
//     -> psw monotone, +1 per 100 cycles, never exceeds 7.
//     -> fault_in with cmd_valid in the same cycle leaves tgt_speed=0.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor ramp controller.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DEAD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int SPEED_W_DEF = 3;

  // Largest speed code representable in w bits.
  function automatic int psw_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/motor_step_timer.sv
// Reloading down-counter: ticks once every CYCLES enabled clocks after a clear.
module motor_step_timer #(
  parameter int CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable) begin
      cnt <= (cnt == '0) ? LOAD : cnt - CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tick = enable && !clear && (cnt == '0);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for the dc_motor PWM block: ramps psw one code per step,
// inserts a dead time around direction reversal and latches faults until cleared.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int SPEED_W     = SPEED_W_DEF,
  parameter int STEP_CYCLES = 100,
  parameter int DEAD_CYCLES = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SPEED_W-1:0] cmd_speed,
  input  logic               cmd_dir,
  input  logic               fault_in,
  input  logic               fault_clr,
  output logic [SPEED_W-1:0] psw,
  output logic               dir,
  output logic               busy,
  output logic               at_speed,
  output logic               fault_latched
);

  localparam logic [SPEED_W-1:0] PSW_MAX = SPEED_W'(psw_max(SPEED_W));

  state_e             state;
  logic [SPEED_W-1:0] tgt_speed;
  logic               tgt_dir;
  logic               accept;
  logic               step_tick;
  logic               dead_tick;
  logic [SPEED_W-1:0] new_speed;
  logic               new_dir;
  logic [SPEED_W-1:0] eff;
  logic [SPEED_W-1:0] psw_step;

  assign cmd_ready     = (state == IDLE) || (state == RAMP);
  assign accept        = cmd_valid && cmd_ready;
  assign busy          = (state != IDLE);
  assign at_speed      = (state == IDLE);
  assign fault_latched = (state == FAULT);

  motor_step_timer #(.CYCLES(STEP_CYCLES)) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state != RAMP) || fault_in),
    .enable (state == RAMP),
    .tick   (step_tick)
  );

  motor_step_timer #(.CYCLES(DEAD_CYCLES)) u_dead_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state != DEAD) || fault_in),
    .enable (state == DEAD),
    .tick   (dead_tick)
  );

  // A command accepted this cycle already steers the step it coincides with.
  always_comb begin
    new_speed = accept ? cmd_speed : tgt_speed;
    new_dir   = accept ? cmd_dir : tgt_dir;
    eff       = (new_dir != dir) ? '0 : new_speed;
    psw_step  = psw;
    if (step_tick) begin
      if ((psw < eff) && (psw != PSW_MAX)) begin
        psw_step = psw + SPEED_W'(1);
      end else if (psw > eff) begin
        psw_step = psw - SPEED_W'(1);
      end else begin
        psw_step = psw;
      end
    end else begin
      psw_step = psw;
    end
  end

  // Sequencing FSM with target and drive registers; fault overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      psw       <= '0;
      dir       <= 1'b0;
      tgt_speed <= '0;
      tgt_dir   <= 1'b0;
    end else if (fault_in) begin
      state     <= FAULT;
      psw       <= '0;
      tgt_speed <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_speed <= cmd_speed;
            tgt_dir   <= cmd_dir;
            if ((cmd_speed == psw) && (cmd_dir == dir)) begin
              state <= IDLE;
            end else if ((psw == '0) && (cmd_dir != dir)) begin
              state <= DEAD;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          tgt_speed <= new_speed;
          tgt_dir   <= new_dir;
          psw       <= psw_step;
          if ((psw_step == eff) && (dir == new_dir)) begin
            state <= IDLE;
          end else if ((psw_step == '0) && (eff == '0)) begin
            state <= DEAD;
          end else begin
            state <= RAMP;
          end
        end
        DEAD: begin
          psw <= '0;
          if (dead_tick) begin
            dir   <= tgt_dir;
            state <= (tgt_speed == '0) ? IDLE : RAMP;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          psw   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench: a time-stamped reference model predicts every cycle's outputs,
// a monitor on the falling edge compares them against the controller.
module tb_motor_ramp_ctrl;

  localparam int STEP = 100;
  localparam int DEAD = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_speed = 3'd0;
  logic       cmd_dir = 1'b0;
  logic       fault_in = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] psw;
  logic       dir;
  logic       busy;
  logic       at_speed;
  logic       fault_latched;

  motor_ramp_ctrl #(.SPEED_W(3), .STEP_CYCLES(STEP), .DEAD_CYCLES(DEAD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_speed     (cmd_speed),
    .cmd_dir       (cmd_dir),
    .fault_in      (fault_in),
    .fault_clr     (fault_clr),
    .psw           (psw),
    .dir           (dir),
    .busy          (busy),
    .at_speed      (at_speed),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: absolute-time schedule of the next step and of the direction flip.
  int m_psw = 0, m_dir = 0, m_tgt = 0, m_tdir = 0;
  int m_next_step = -1, m_dead_end = -1;
  bit m_fault = 1'b0;

  function automatic bit m_ready();
    return !m_fault && (m_dead_end < 0);
  endfunction

  function automatic bit m_busy();
    return m_fault || (m_dead_end >= 0) || (m_next_step >= 0);
  endfunction

  function automatic int toward(input int p, input int e);
    return (p < e) ? p + 1 : ((p > e) ? p - 1 : p);
  endfunction

  task automatic model_edge();
    int  eff;
    bit  moving;
    if (!rst_n) begin
      m_psw = 0; m_dir = 0; m_tgt = 0; m_tdir = 0;
      m_fault = 1'b0; m_next_step = -1; m_dead_end = -1;
    end else if (fault_in) begin
      m_psw = 0; m_tgt = 0; m_fault = 1'b1; m_next_step = -1; m_dead_end = -1;
    end else if (m_fault) begin
      if (fault_clr) m_fault = 1'b0;
    end else if (m_dead_end >= 0) begin
      if (cyc == m_dead_end) begin
        m_dir = m_tdir;
        m_dead_end = -1;
        m_next_step = (m_tgt != 0) ? cyc + STEP : -1;
      end
    end else begin
      moving = (m_next_step >= 0);
      if (cmd_valid) begin
        m_tgt  = int'(cmd_speed);
        m_tdir = int'(cmd_dir);
      end
      if (!moving) begin
        if (cmd_valid && !((m_tgt == m_psw) && (m_tdir == m_dir))) begin
          if ((m_psw == 0) && (m_tdir != m_dir)) m_dead_end = cyc + DEAD;
          else m_next_step = cyc + STEP;
        end
      end else begin
        eff = (m_tdir != m_dir) ? 0 : m_tgt;
        if (cyc == m_next_step) begin
          m_psw = toward(m_psw, eff);
          m_next_step = cyc + STEP;
        end
        if ((m_psw == eff) && (m_dir == m_tdir)) begin
          m_next_step = -1;
        end else if ((m_psw == 0) && (eff == 0)) begin
          m_next_step = -1;
          m_dead_end = cyc + DEAD;
        end
      end
    end
  endtask

  // Model advances on every rising edge and queues the outputs it predicts.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_edge();
      e.cyc = cyc;
      e.v = {m_psw[2:0], m_dir[0], m_busy(), !m_busy(), m_fault, m_ready()};
      exp_q.push_back(e);
    end
  end

  // Monitor: compares the controller outputs with the oldest prediction.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {psw, dir, busy, at_speed, fault_latched, cmd_ready};
        checks = checks + 1;
        if (act !== e.v) begin
          errors = errors + 1;
          if (errors < 20)
            $display("FAIL scoreboard cyc=%0d got psw,dir,busy,at_speed,fault,ready=%b want %b",
                     e.cyc, act, e.v);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic issue(input int s, input int d, output int t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!m_ready() && (guard < 3000)) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (guard >= 3000) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL issue_timeout cyc=%0d got not-ready want ready", cyc);
    end
    cmd_valid = 1'b1;
    cmd_speed = s[2:0];
    cmd_dir   = d[0];
    t = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_busy() && (guard < 3000)) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (guard >= 3000) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL idle_timeout cyc=%0d got busy want idle", cyc);
    end
  endtask

  task automatic inject_fault(input int len);
    @(negedge clk);
    fault_in = 1'b1;
    repeat (len) @(negedge clk);
    fault_in  = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  initial begin
    int t, k;
    repeat (3) @(negedge clk);
    chk("reset_psw", int'(psw), 0);
    chk("reset_at_speed", int'(at_speed), 1);
    chk("reset_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;

    // Soft start to 5.
    issue(5, 0, t);
    wait_cyc(t + 99);  chk("start_psw_pre", int'(psw), 0);
    wait_cyc(t + 100); chk("start_psw1", int'(psw), 1);
    wait_cyc(t + 499); chk("start_busy", int'(busy), 1);
    wait_cyc(t + 500); chk("start_psw5", int'(psw), 5);
    chk("start_at_speed", int'(at_speed), 1);

    // Reversal to 3 in direction 1.
    issue(3, 1, t);
    wait_cyc(t + 500); chk("rev_psw0", int'(psw), 0);
    wait_cyc(t + 520); chk("rev_dead_ready", int'(cmd_ready), 0);
    wait_cyc(t + 549); chk("rev_dir_pre", int'(dir), 0);
    wait_cyc(t + 550); chk("rev_dir", int'(dir), 1);
    wait_cyc(t + 850); chk("rev_psw3", int'(psw), 3);
    chk("rev_at_speed", int'(at_speed), 1);

    // Fault at psw=2; clear ignored while fault_in is high.
    issue(2, 1, t);
    wait_cyc(t + 100); chk("pre_fault_psw", int'(psw), 2);
    fault_in = 1'b1; k = cyc;
    wait_cyc(k + 1);
    chk("fault_psw", int'(psw), 0);
    chk("fault_latched", int'(fault_latched), 1);
    chk("fault_ready", int'(cmd_ready), 0);
    wait_cyc(k + 5);  fault_clr = 1'b1;
    wait_cyc(k + 6);  fault_clr = 1'b0;
    wait_cyc(k + 10); fault_in = 1'b0;
    wait_cyc(k + 11); chk("fault_held", int'(fault_latched), 1);
    wait_cyc(k + 12); fault_clr = 1'b1;
    wait_cyc(k + 13); fault_clr = 1'b0;
    chk("fault_cleared", int'(fault_latched), 0);
    wait_cyc(k + 60); chk("no_restart_psw", int'(psw), 0);

    // Retarget 7 -> 1 at psw=3 keeps the step phase.
    issue(7, 0, t);
    wait_cyc(t + 350); chk("rt_psw3", int'(psw), 3);
    wait_cyc(t + 390);
    issue(1, 0, k);
    wait_cyc(t + 449); chk("rt_psw_hold", int'(psw), 3);
    wait_cyc(t + 450); chk("rt_psw2", int'(psw), 2);
    wait_cyc(t + 550); chk("rt_psw1", int'(psw), 1);
    chk("rt_at_speed", int'(at_speed), 1);

    // Reset in the middle of operation at psw=4, dir=1.
    issue(4, 1, t);
    wait_cyc(t + 560);
    chk("mid_psw4", int'(psw), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_psw", int'(psw), 0);
    chk("async_dir", int'(dir), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("post_reset_ready", int'(cmd_ready), 1);

    // Sweep every speed code.
    for (int i = 0; i < 8; i++) begin
      issue(i, 0, t);
      wait_idle();
      chk("sweep_psw", int'(psw), i);
    end

    // Fault in the same cycle as a command: the command is dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_speed = 3'd6; cmd_dir = 1'b0; fault_in = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; fault_in = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (150) @(negedge clk);
    chk("dropped_cmd_psw", int'(psw), 0);
    chk("dropped_cmd_idle", int'(at_speed), 1);

    // Randomized commands with occasional fault pulses.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        inject_fault(int'($urandom_range(1, 5)));
      end else begin
        issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), t);
        repeat ($urandom_range(0, 700)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
